// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, write-controller states and the address decode helper
package regfile_pkg;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {
        RUN = 2'b00,
        DRAIN = 2'b01,
        INIT = 2'b10
    } state_e;
    function automatic logic [NUM_REGS-1:0] onehot5to32(input logic [ADDR_W-1:0] a);
        return NUM_REGS'(1) << a;
    endfunction
endpackage

// File: rtl/regfile_write_ctrl_wr_fifo.sv
// wr_fifo: synchronous FIFO with extra-MSB pointers so full/empty fall out of a single compare
module wr_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 37
) (
    input  logic                     clk_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic do_push, do_pop;
    assign full_o = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = wptr_q == rptr_q;
    assign count_o = wptr_q - rptr_q;
    assign dout_o = mem_q[rptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop = pop_i && !empty_o;
    assign wptr_d = wptr_q + (AW+1)'(do_push);
    assign rptr_d = rptr_q + (AW+1)'(do_pop);
    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: buffered write-back front end for the register file with a zero-fill sequencer
module regfile_write_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                clk_i,
    input  logic                clr_i,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                init_req_i,
    output logic                busy_o,
    output logic [DATA_W-1:0]   write_o,
    output logic [NUM_REGS-1:0] en_o
);
    localparam int AW = $clog2(DEPTH);
    state_e state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [NUM_REGS-1:0] en_q, en_d;
    logic [DATA_W-1:0] write_q, write_d;
    logic wr_ready_q, wr_ready_d;
    logic push, pop, full, empty;
    logic [AW:0] count, occ_d;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    assign push = wr_valid_i && wr_ready_q && !full;
    assign pop = (state_q != INIT) && !empty;
    wr_fifo #(
        .DEPTH(DEPTH),
        .W(ADDR_W + DATA_W)
    ) u_fifo (
        .clk_i(clk_i),
        .clr_i(clr_i),
        .push_i(push),
        .pop_i(pop),
        .din_i({wr_addr_i, wr_data_i}),
        .dout_o({head_addr, head_data}),
        .full_o(full),
        .empty_o(empty),
        .count_o(count)
    );
    // DRAIN leaves on the edge of its last pop so the fill follows the queued writes without a gap
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        en_d = '0;
        write_d = write_q;
        occ_d = count + (AW+1)'(push) - (AW+1)'(pop);
        if (pop) begin
            en_d = (head_addr == '0) ? '0 : onehot5to32(head_addr);
            write_d = head_data;
        end
        if (state_q == INIT) begin
            en_d = onehot5to32(cnt_q);
            write_d = '0;
            cnt_d = cnt_q + ADDR_W'(1);
            state_d = (cnt_q == ADDR_W'(NUM_REGS - 1)) ? RUN : INIT;
        end else if (state_q == DRAIN) begin
            cnt_d = ADDR_W'(1);
            state_d = (occ_d == '0) ? INIT : DRAIN;
        end else begin
            state_d = init_req_i ? DRAIN : RUN;
        end
        wr_ready_d = (state_d == RUN) && (occ_d != (AW+1)'(DEPTH));
    end
    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            state_q <= INIT_ON_RESET ? INIT : RUN;
            cnt_q <= ADDR_W'(1);
            en_q <= '0;
            write_q <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            en_q <= en_d;
            write_q <= write_d;
            wr_ready_q <= wr_ready_d;
        end
    end
    assign wr_ready_o = wr_ready_q;
    assign busy_o = state_q != RUN;
    assign write_o = write_q;
    assign en_o = en_q;
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb_regfile_write_ctrl: scoreboard bench for the register-file write front end
module tb_regfile_write_ctrl;
    logic clk = 1'b0;
    logic clr_i = 1'b0;
    logic wr_valid_i = 1'b0;
    logic wr_ready_o;
    logic [4:0] wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic init_req_i = 1'b0;
    logic busy_o;
    logic [31:0] write_o;
    logic [31:0] en_o;
    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    typedef struct {
        int cyc;
        logic [31:0] en;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    regfile_write_ctrl #(
        .DEPTH(2),
        .INIT_ON_RESET(1'b1)
    ) dut (
        .clk_i(clk),
        .clr_i(clr_i),
        .wr_valid_i(wr_valid_i),
        .wr_ready_o(wr_ready_o),
        .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i),
        .init_req_i(init_req_i),
        .busy_o(busy_o),
        .write_o(write_o),
        .en_o(en_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_fill(input int start);
        for (int i = 0; i < 31; i++) sb.push_back('{start + i, 32'h2 << i, 32'h0});
    endtask

    task automatic send(input logic [4:0] a, input logic [31:0] d, input logic ir);
        chk("wr_ready", {31'h0, wr_ready_o}, 32'h1);
        wr_valid_i = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        init_req_i = ir;
        if (a != 5'd0) sb.push_back('{cyc + 2, 32'h1 << a, d});
        @(negedge clk);
        wr_valid_i = 1'b0;
        init_req_i = 1'b0;
    endtask

    task automatic watch_busy(input int n, input bit pulse);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            init_req_i = pulse && (i == 5);
            chk("busy", {31'h0, busy_o}, 32'h1);
            chk("ready_low", {31'h0, wr_ready_o}, 32'h0);
        end
        init_req_i = 1'b0;
        @(negedge clk);
        chk("busy_end", {31'h0, busy_o}, 32'h0);
        chk("ready_up", {31'h0, wr_ready_o}, 32'h1);
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                chk("en", en_o, sb[0].en);
                chk("write", write_o, sb[0].d);
                void'(sb.pop_front());
            end else begin
                chk("idle_en", en_o, 32'h0);
            end
        end
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_en", en_o, 32'h0);
        chk("rst_write", write_o, 32'h0);
        chk("rst_ready", {31'h0, wr_ready_o}, 32'h0);
        chk("rst_busy", {31'h0, busy_o}, 32'h1);
        push_fill(cyc + 1);
        clr_i = 1'b1;
        watch_busy(30, 1'b0);
        send(5'd5, 32'hDEADBEEF, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 10; i++) send(5'(i), 32'hA500_0000 + 32'(i), 1'b0);
        repeat (3) @(negedge clk);
        send(5'd0, 32'hFFFFFFFF, 1'b0);
        repeat (3) @(negedge clk);
        send(5'd3, 32'h3333_0003, 1'b0);
        send(5'd7, 32'h7777_0007, 1'b1);
        chk("drain_ready", {31'h0, wr_ready_o}, 32'h0);
        chk("drain_busy", {31'h0, busy_o}, 32'h1);
        push_fill(cyc + 2);
        repeat (13) begin
            @(negedge clk);
            chk("fill_busy", {31'h0, busy_o}, 32'h1);
        end
        clr_i = 1'b0;
        while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
        @(negedge clk);
        chk("midrst_en", en_o, 32'h0);
        chk("midrst_busy", {31'h0, busy_o}, 32'h1);
        chk("midrst_ready", {31'h0, wr_ready_o}, 32'h0);
        push_fill(cyc + 1);
        clr_i = 1'b1;
        watch_busy(30, 1'b1);
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
